mmio_ctrl: RTL and testbench

- Parametrised successor to the CPU's combinational memory-map decoder: decodes data-side addresses into instruction-memory and data-memory write enables plus an I/O region, and owns the I/O registers itself.
- Adds a one-entry UART TX buffer, a one-entry UART RX buffer, cycle and retired-instruction counters, and a registered read path aligned with synchronous BRAM latency.
- Sits between the MEM stage and the data BRAM/IMEM/UART.
- Stall-aware: no side effects while the pipeline is stalled.

---
 rtl/mmio_pkg.sv | 27 ++
 rtl/mmio_counters.sv | 45 ++++
 rtl/mmio_ctrl.sv | 148 ++++++++++++++
 tb/tb_mmio_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped I/O controller.
// Offsets are the low address byte inside the I/O region.
package mmio_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned OFS_W = 8;

  localparam logic [OFS_W-1:0] OFS_TXSTAT = 8'h00;
  localparam logic [OFS_W-1:0] OFS_RXSTAT = 8'h04;
  localparam logic [OFS_W-1:0] OFS_TXDATA = 8'h08;
  localparam logic [OFS_W-1:0] OFS_RXDATA = 8'h0C;
  localparam logic [OFS_W-1:0] OFS_CYC    = 8'h10;
  localparam logic [OFS_W-1:0] OFS_INSTR  = 8'h14;
  localparam logic [OFS_W-1:0] OFS_CTRCLR = 8'h18;

  // Region nibble: bit 3 marks I/O space, bit 0 selects DMEM, bit 1 selects IMEM.
  localparam logic [NIB_W-1:0] NIB_IO     = 4'b1000;
  localparam int unsigned      NIB_IO_BIT = 3;
  localparam int unsigned      NIB_DM_BIT = 0;
  localparam int unsigned      NIB_IM_BIT = 1;

  typedef enum logic {
    RDSEL_BRAM = 1'b0,
    RDSEL_IO   = 1'b1
  } rdsel_e;

endpackage

// File: rtl/mmio_counters.sv
// Free-running cycle counter and retired-instruction counter with a shared
// synchronous clear that takes priority over increments.
module mmio_counters
  import mmio_pkg::*;
#(
  parameter int unsigned CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_inc_i,
  input  logic             instr_inc_i,
  input  logic             clr_i,
  output logic [CTR_W-1:0] cyc_o,
  output logic [CTR_W-1:0] instr_o
);

  logic [CTR_W-1:0] cyc_q, cyc_d;
  logic [CTR_W-1:0] instr_q, instr_d;

  always_comb begin
    cyc_d   = cyc_q;
    instr_d = instr_q;
    if (clr_i) begin
      cyc_d   = '0;
      instr_d = '0;
    end else begin
      if (cyc_inc_i)   cyc_d   = cyc_q + CTR_W'(1);
      if (instr_inc_i) instr_d = instr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/mmio_ctrl.sv
// Data-side memory-map decoder and I/O register block: memory write enables,
// single-entry UART TX/RX buffers, counters and a 1-cycle registered read path.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned      ADDR_W = 32,
  parameter int unsigned      DATA_W = 32,
  parameter int unsigned      UART_W = 8,
  parameter int unsigned      CTR_W  = 32,
  parameter logic [NIB_W-1:0] IO_NIB = NIB_IO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Stall,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              InstrRetired,
  output logic              WEIM,
  output logic              WEDM,
  output logic              RDsel,
  output logic [DATA_W-1:0] IORdata,
  output logic [UART_W-1:0] DataIn,
  output logic              DataInValid,
  input  logic              DataInReady,
  input  logic [UART_W-1:0] DataOut,
  input  logic              DataOutValid,
  output logic              DataOutReady
);

  logic [NIB_W-1:0] nib;
  logic [OFS_W-1:0] ofs;
  logic             io, rd, wr;
  logic             tx_wr, rx_pop, ctr_clr;

  rdsel_e           rdsel_q, rdsel_d;
  logic [DATA_W-1:0] iordata_q, iordata_d, rd_val;
  logic [UART_W-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic [UART_W-1:0] rx_byte_q, rx_byte_d;
  logic             rx_full_q, rx_full_d;
  logic [CTR_W-1:0]  cyc, instr;

  assign nib = Address[ADDR_W-1 -: NIB_W];
  assign ofs = Address[OFS_W-1:0];
  assign io  = (nib == IO_NIB);
  assign rd  = MemRead  & io & ~Stall;
  assign wr  = MemWrite & io & ~Stall;

  assign tx_wr   = wr & (ofs == OFS_TXDATA);
  assign ctr_clr = wr & (ofs == OFS_CTRCLR);
  assign rx_pop  = rd & (ofs == OFS_RXDATA) & rx_full_q;

  assign WEDM = MemWrite & ~Stall & ~nib[NIB_IO_BIT] & nib[NIB_DM_BIT];
  assign WEIM = MemWrite & ~Stall & ~nib[NIB_IO_BIT] & nib[NIB_IM_BIT];

  // Address bits between the region nibble and the offset byte carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{Address[ADDR_W-NIB_W-1:OFS_W], WriteData[DATA_W-1:UART_W]};

  mmio_counters #(
    .CTR_W (CTR_W)
  ) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .cyc_inc_i   (1'b1),
    .instr_inc_i (InstrRetired),
    .clr_i       (ctr_clr),
    .cyc_o       (cyc),
    .instr_o     (instr)
  );

  // Read mux over pre-edge state, so a combined load/store sees the old value.
  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_TXSTAT: rd_val = DATA_W'({tx_ovf_q, ~tx_valid_q});
      OFS_RXSTAT: rd_val = DATA_W'(rx_full_q);
      OFS_RXDATA: rd_val = DATA_W'(rx_byte_q);
      OFS_CYC:    rd_val = DATA_W'(cyc);
      OFS_INSTR:  rd_val = DATA_W'(instr);
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    rdsel_d    = rdsel_q;
    iordata_d  = iordata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_ovf_d   = tx_ovf_q;
    rx_byte_d  = rx_byte_q;
    rx_full_d  = rx_full_q;

    if (!Stall) begin
      rdsel_d   = rd ? RDSEL_IO : RDSEL_BRAM;
      iordata_d = rd ? rd_val : '0;
    end

    // A write racing the handshake still sees the buffer as full.
    if (tx_valid_q && DataInReady) tx_valid_d = 1'b0;
    if (tx_wr) begin
      if (tx_valid_q) begin
        tx_ovf_d = 1'b1;
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = WriteData[UART_W-1:0];
      end
    end
    if (ctr_clr) tx_ovf_d = 1'b0;

    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (DataOutValid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = DataOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdsel_q    <= RDSEL_BRAM;
      iordata_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_byte_q  <= '0;
      rx_full_q  <= 1'b0;
    end else begin
      rdsel_q    <= rdsel_d;
      iordata_q  <= iordata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_byte_q  <= rx_byte_d;
      rx_full_q  <= rx_full_d;
    end
  end

  assign RDsel        = rdsel_q;
  assign IORdata      = iordata_q;
  assign DataIn       = tx_data_q;
  assign DataInValid  = tx_valid_q;
  assign DataOutReady = ~rx_full_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Randomized plus directed bench for mmio_ctrl against a cycle-level reference model.
// Counters are narrowed to 8 bits so the wrap is reached by simply running.
module tb_mmio_ctrl;

  localparam int unsigned CTR_W   = 8;
  localparam int unsigned CTR_MOD = 1 << CTR_W;

  logic        clk, rst_n;
  logic        MemWrite, MemRead, Stall, InstrRetired;
  logic [31:0] Address, WriteData;
  logic        WEIM, WEDM, RDsel;
  logic [31:0] IORdata;
  logic [7:0]  DataIn, DataOut;
  logic        DataInValid, DataInReady, DataOutValid, DataOutReady;

  mmio_ctrl #(.CTR_W(CTR_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .Stall        (Stall),
    .Address      (Address),
    .WriteData    (WriteData),
    .InstrRetired (InstrRetired),
    .WEIM         (WEIM),
    .WEDM         (WEDM),
    .RDsel        (RDsel),
    .IORdata      (IORdata),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, described in terms of the programmer-visible registers.
  bit          m_tx_valid, m_ovf, m_rx_full, m_rdsel;
  logic [7:0]  m_tx_byte, m_rx_byte;
  int unsigned m_cyc, m_instr;
  logic [31:0] m_iordata;

  logic [7:0] ofs_tbl [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                               8'h14, 8'h18, 8'h1C, 8'h40, 8'h0C};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx_valid = 0; m_ovf = 0; m_rx_full = 0; m_rdsel = 0;
    m_tx_byte = 8'h00; m_rx_byte = 8'h00;
    m_cyc = 0; m_instr = 0; m_iordata = 32'h0;
  endtask

  function automatic logic [31:0] io_value(input logic [7:0] ofs);
    case (ofs)
      8'h00:   return {30'd0, m_ovf, !m_tx_valid};
      8'h04:   return {31'd0, m_rx_full};
      8'h0C:   return {24'd0, m_rx_byte};
      8'h10:   return 32'(m_cyc);
      8'h14:   return 32'(m_instr);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_wedm();
    int unsigned n = int'(Address[31:28]);
    return MemWrite && !Stall && (n < 8) && (n % 2 == 1);
  endfunction

  function automatic logic exp_weim();
    int unsigned n = int'(Address[31:28]);
    return MemWrite && !Stall && (n < 8) && ((n / 2) % 2 == 1);
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit          io, rd, wr, was_valid, was_full;
    logic [7:0]  ofs;
    logic [31:0] val;
    io  = (Address[31:28] == 4'h8);
    ofs = Address[7:0];
    rd  = MemRead && io && !Stall;
    wr  = MemWrite && io && !Stall;
    val = io_value(ofs);
    was_valid = m_tx_valid;
    was_full  = m_rx_full;
    if (!Stall) begin
      m_rdsel   = rd;
      m_iordata = rd ? val : 32'h0;
    end
    if (was_valid && DataInReady) m_tx_valid = 0;
    if (wr && ofs == 8'h08) begin
      if (was_valid) m_ovf = 1;
      else begin
        m_tx_valid = 1;
        m_tx_byte  = WriteData[7:0];
      end
    end
    if (rd && ofs == 8'h0C && was_full) m_rx_full = 0;
    else if (DataOutValid && !was_full) begin
      m_rx_full = 1;
      m_rx_byte = DataOut;
    end
    if (wr && ofs == 8'h18) begin
      m_ovf = 0; m_cyc = 0; m_instr = 0;
    end else begin
      m_cyc = (m_cyc + 1) % CTR_MOD;
      if (InstrRetired) m_instr = (m_instr + 1) % CTR_MOD;
    end
  endtask

  // One cycle: inputs already applied at the falling edge.
  task automatic tick();
    #1;
    check("WEDM", 32'(WEDM), 32'(exp_wedm()));
    check("WEIM", 32'(WEIM), 32'(exp_weim()));
    @(posedge clk);
    model_edge();
    #1;
    check("RDsel", 32'(RDsel), 32'(m_rdsel));
    check("IORdata", IORdata, m_iordata);
    check("DataIn", 32'(DataIn), 32'(m_tx_byte));
    check("DataInValid", 32'(DataInValid), 32'(m_tx_valid));
    check("DataOutReady", 32'(DataOutReady), 32'(!m_rx_full));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MemWrite = 0; MemRead = 0; Stall = 0; InstrRetired = 0;
    Address = 32'h0; WriteData = 32'h0;
    DataInReady = 0; DataOut = 8'h00; DataOutValid = 0;
  endtask

  task automatic io_write(input logic [7:0] ofs, input logic [31:0] d);
    idle_inputs();
    MemWrite = 1; Address = {24'h800000, ofs}; WriteData = d;
    tick();
  endtask

  task automatic io_read(input logic [7:0] ofs);
    idle_inputs();
    MemRead = 1; Address = {24'h800000, ofs};
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_RDsel", 32'(RDsel), 32'h0);
    check("rst_IORdata", IORdata, 32'h0);
    check("rst_DataInValid", 32'(DataInValid), 32'h0);
    check("rst_DataOutReady", 32'(DataOutReady), 32'h1);
    rst_n = 1;

    // Region decode.
    idle_inputs(); MemWrite = 1; Address = 32'h1000_0040; #1;
    check("dec_dm_wedm", 32'(WEDM), 32'h1);
    check("dec_dm_weim", 32'(WEIM), 32'h0);
    tick();
    MemWrite = 1; Address = 32'h3000_0040; #1;
    check("dec_mirror_wedm", 32'(WEDM), 32'h1);
    check("dec_mirror_weim", 32'(WEIM), 32'h1);
    tick();
    idle_inputs(); MemWrite = 1; Address = 32'h8000_0008; Stall = 1; #1;
    check("dec_io_stall", 32'({WEIM, WEDM}), 32'h0);
    tick();
    Stall = 0; #1;
    check("dec_io", 32'({WEIM, WEDM}), 32'h0);
    tick();
    idle_inputs(); DataInReady = 1; tick();
    io_write(8'h18, 32'h0);

    // TX buffer: hold, overflow, drain.
    io_write(8'h08, 32'h0000_0041);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); tick();
      check("tx_hold_byte", 32'(DataIn), 32'h41);
      check("tx_hold_valid", 32'(DataInValid), 32'h1);
    end
    io_write(8'h08, 32'h0000_0099);
    check("tx_ovf_keep", 32'(DataIn), 32'h41);
    io_read(8'h00);
    check("tx_ovf_status", IORdata, 32'h2);
    idle_inputs(); DataInReady = 1; tick();
    check("tx_drained", 32'(DataInValid), 32'h0);

    // RX buffer: capture, status, pop.
    idle_inputs(); DataOut = 8'h5A; DataOutValid = 1; tick();
    check("rx_ready_low", 32'(DataOutReady), 32'h0);
    io_read(8'h04);
    check("rx_full_status", IORdata, 32'h1);
    io_read(8'h0C);
    check("rx_pop_data", IORdata, 32'h5A);
    check("rx_pop_rdsel", 32'(RDsel), 32'h1);
    io_read(8'h04);
    check("rx_empty_status", IORdata, 32'h0);

    // Counters.
    idle_inputs(); MemWrite = 1; Address = 32'h8000_0018; InstrRetired = 1; tick();
    for (int i = 0; i < 10; i++) begin
      idle_inputs(); InstrRetired = (i == 1 || i == 3 || i == 6 || i == 8); tick();
    end
    io_read(8'h14);
    check("instr_count4", IORdata, 32'h4);
    idle_inputs(); MemWrite = 1; Address = 32'h8000_0018; InstrRetired = 1; tick();
    io_read(8'h10);
    check("clr_cyc", IORdata, 32'h0);
    io_read(8'h14);
    check("clr_instr", IORdata, 32'h0);

    // Cycle counter wrap from all-ones.
    io_write(8'h18, 32'h0);
    for (int i = 0; i < 255; i++) begin
      idle_inputs(); tick();
    end
    io_read(8'h10);
    check("cyc_allones", IORdata, 32'hFF);
    io_read(8'h10);
    check("cyc_wrapped", IORdata, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      MemWrite     = ($urandom_range(0, 3) == 0);
      MemRead      = ($urandom_range(0, 2) == 0);
      Stall        = ($urandom_range(0, 4) == 0);
      InstrRetired = 1'($urandom);
      if ($urandom_range(0, 3) != 0)
        Address = {4'h8, 20'($urandom), ofs_tbl[$urandom_range(0, 9)]};
      else
        Address = $urandom;
      WriteData    = $urandom;
      DataInReady  = ($urandom_range(0, 2) == 0);
      DataOutValid = 1'($urandom);
      DataOut      = 8'($urandom);
      tick();
    end

    // Asynchronous reset with both buffers occupied.
    io_write(8'h08, 32'h0000_00C3);
    idle_inputs(); DataOut = 8'hA5; DataOutValid = 1; tick();
    io_read(8'h10);
    check("pre_rst_txvalid", 32'(DataInValid), 32'h1);
    check("pre_rst_rxready", 32'(DataOutReady), 32'h0);
    idle_inputs();
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 0;
    #1;
    check("arst_RDsel", 32'(RDsel), 32'h0);
    check("arst_IORdata", IORdata, 32'h0);
    check("arst_DataIn", 32'(DataIn), 32'h0);
    check("arst_DataInValid", 32'(DataInValid), 32'h0);
    check("arst_DataOutReady", 32'(DataOutReady), 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    io_read(8'h10);
    io_read(8'h00);
    io_read(8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
